// File: rtl/tilexy_pkg.sv
// Shared packet layout and helper types for the tile-mesh response link.
// Packets are {src_y, src_x, dst_y, dst_x, addr, data}, MSB first.
package tilexy_pkg;

    localparam int COORD_W = 5;
    localparam int ADDR_W  = 37;
    localparam int DATA_W  = 528;
    localparam int PKT_W   = 585;

    localparam int PKT_DATA_LSB = 0;
    localparam int PKT_DATA_MSB = 527;
    localparam int PKT_ADDR_LSB = 528;
    localparam int PKT_ADDR_MSB = 564;
    localparam int PKT_DX_LSB   = 565;
    localparam int PKT_DX_MSB   = 569;
    localparam int PKT_DY_LSB   = 570;
    localparam int PKT_DY_MSB   = 574;
    localparam int PKT_SX_LSB   = 575;
    localparam int PKT_SX_MSB   = 579;
    localparam int PKT_SY_LSB   = 580;
    localparam int PKT_SY_MSB   = 584;

    localparam int LANE_BACK = 0;
    localparam int LANE_FWD  = 1;

    typedef enum logic [1:0] {
        ROUTE_BACK = 2'd0,
        ROUTE_FWD  = 2'd1,
        ROUTE_LOOP = 2'd2
    } route_e;

    // Destination coordinates are dropped once a packet reaches the eject queue.
    typedef struct packed {
        logic [2*COORD_W-1:0] src;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
    } eject_entry_t;

endpackage

// File: rtl/tilexy_lane_fifo.sv
// Single-write/single-read synchronous FIFO with occupancy count.
// A push into a full FIFO is dropped; the head is visible combinationally.
module tilexy_lane_fifo #(
    parameter int W     = 585,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/tilexy_resp_link.sv
// Response link stage for one mesh dimension: injects local fills onto the
// back/forward lanes, forwards transit traffic, and ejects packets for this tile.
module tilexy_resp_link
    import tilexy_pkg::*;
#(
    parameter int TILE_X = 0,
    parameter int TILE_Y = 0,
    parameter int DIM    = 0,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [COORD_W-1:0]         in_dst_x,
    input  logic [COORD_W-1:0]         in_dst_y,
    input  logic [1:0][PKT_W-1:0]      lane_in,
    input  logic [1:0]                 lane_in_vld,
    output logic [1:0]                 lane_stall_out,
    output logic [1:0][PKT_W-1:0]      lane_out,
    output logic [1:0]                 lane_out_vld,
    input  logic [1:0]                 lane_stall_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [2*COORD_W-1:0]       out_src
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [COORD_W-1:0]   TILE_C   = (DIM != 0) ? COORD_W'(TILE_Y) : COORD_W'(TILE_X);
    localparam logic [2*COORD_W-1:0] TILE_SRC = {COORD_W'(TILE_Y), COORD_W'(TILE_X)};
    localparam logic [CW-1:0] TCNT_STALL    = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ECNT_STALL    = CW'(DEPTH - 2);
    localparam logic [CW-1:0] ECNT_LOOP_MAX = CW'(DEPTH - 3);
    localparam logic [CW-1:0] ECNT_FULL     = CW'(DEPTH);

    logic [1:0][CW-1:0]    tcnt;
    logic [1:0][PKT_W-1:0] t_head;
    logic [1:0]            t_push;
    logic [1:0]            t_pop;
    logic [1:0]            t_empty;
    logic [1:0]            lane_match;
    logic [1:0]            inj_lane;

    logic [COORD_W-1:0]    inj_coord;
    route_e                route;
    logic                  inj_fire;
    logic                  inj_loop;
    logic [PKT_W-1:0]      inj_pkt;

    eject_entry_t          eq_mem [DEPTH];
    eject_entry_t          e_head;
    logic [2:0][$bits(eject_entry_t)-1:0] e_wdata;
    logic [2:0]            e_req;
    logic [2:0]            e_wen;
    logic [2:0][AW-1:0]    e_widx;
    logic [1:0]            e_nwr;
    logic [CW-1:0]         e_free;
    logic [CW-1:0]         ecnt;
    logic [AW-1:0]         e_wptr;
    logic [AW-1:0]         e_rptr;
    logic                  e_pop;

    for (genvar i = 0; i < 2; i++) begin : g_lane
        assign lane_match[i] = ((DIM != 0) ? lane_in[i][PKT_DY_MSB:PKT_DY_LSB]
                                           : lane_in[i][PKT_DX_MSB:PKT_DX_LSB]) == TILE_C;
        assign t_push[i] = lane_in_vld[i] && !lane_match[i];
        assign t_pop[i]  = !lane_stall_in[i] && !t_empty[i];
        assign lane_stall_out[i] = (tcnt[i] >= TCNT_STALL) || (ecnt >= ECNT_STALL);

        tilexy_lane_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (t_push[i]),
            .push_data (lane_in[i]),
            .pop       (t_pop[i]),
            .head      (t_head[i]),
            .count     (tcnt[i]),
            .empty     (t_empty[i])
        );
    end

    assign inj_coord = (DIM != 0) ? in_dst_y : in_dst_x;
    assign inj_pkt   = {TILE_SRC, in_dst_y, in_dst_x, in_addr, in_data};

    // Inject only into an idle lane so transit traffic always wins.
    always_comb begin
        if (inj_coord == TILE_C)     route = ROUTE_LOOP;
        else if (inj_coord > TILE_C) route = ROUTE_FWD;
        else                         route = ROUTE_BACK;
        case (route)
            ROUTE_BACK: in_ready = !lane_stall_in[LANE_BACK] && t_empty[LANE_BACK];
            ROUTE_FWD:  in_ready = !lane_stall_in[LANE_FWD] && t_empty[LANE_FWD];
            default:    in_ready = (ecnt <= ECNT_LOOP_MAX);
        endcase
    end

    assign inj_fire           = in_valid && in_ready;
    assign inj_lane[LANE_BACK] = inj_fire && (route == ROUTE_BACK);
    assign inj_lane[LANE_FWD]  = inj_fire && (route == ROUTE_FWD);
    assign inj_loop           = inj_fire && (route == ROUTE_LOOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_out     <= '0;
            lane_out_vld <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (t_pop[l]) begin
                    lane_out[l]     <= t_head[l];
                    lane_out_vld[l] <= 1'b1;
                end else if (inj_lane[l]) begin
                    lane_out[l]     <= inj_pkt;
                    lane_out_vld[l] <= 1'b1;
                end else begin
                    lane_out_vld[l] <= 1'b0;
                end
            end
        end
    end

    assign e_req   = {inj_loop, lane_in_vld[1] && lane_match[1], lane_in_vld[0] && lane_match[0]};
    assign e_wdata = {{TILE_SRC, in_addr, in_data},
                      {lane_in[1][PKT_SY_MSB:PKT_SX_LSB], lane_in[1][PKT_ADDR_MSB:PKT_DATA_LSB]},
                      {lane_in[0][PKT_SY_MSB:PKT_SX_LSB], lane_in[0][PKT_ADDR_MSB:PKT_DATA_LSB]}};
    assign e_pop   = out_valid && out_ready;
    assign e_free  = ECNT_FULL - ecnt + CW'(e_pop);

    // Pack accepted writes into consecutive slots; the pop frees its slot first.
    always_comb begin
        e_nwr  = '0;
        e_wen  = '0;
        e_widx = '0;
        for (int k = 0; k < 3; k++) begin
            e_widx[k] = e_wptr + AW'(e_nwr);
            if (e_req[k] && (CW'(e_nwr) < e_free)) begin
                e_wen[k] = 1'b1;
                e_nwr    = e_nwr + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (e_wen[k]) eq_mem[e_widx[k]] <= e_wdata[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_wptr <= '0;
            e_rptr <= '0;
            ecnt   <= '0;
        end else begin
            e_wptr <= e_wptr + AW'(e_nwr);
            e_rptr <= e_rptr + AW'(e_pop);
            ecnt   <= ecnt + CW'(e_nwr) - CW'(e_pop);
        end
    end

    assign e_head    = eq_mem[e_rptr];
    assign out_valid = (ecnt != '0);
    assign out_data  = e_head.data;
    assign out_addr  = e_head.addr;
    assign out_src   = e_head.src;

endmodule

// File: tb/tb_tilexy_resp_link.sv
// Directed bench for tilexy_resp_link as tile X=2 on the X dimension, DEPTH=8.
module tb_tilexy_resp_link;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [527:0]     in_data;
    logic [36:0]      in_addr;
    logic [4:0]       in_dst_x;
    logic [4:0]       in_dst_y;
    logic [1:0][584:0] lane_in;
    logic [1:0]       lane_in_vld;
    logic [1:0]       lane_stall_out;
    logic [1:0][584:0] lane_out;
    logic [1:0]       lane_out_vld;
    logic [1:0]       lane_stall_in;
    logic             out_valid;
    logic             out_ready;
    logic [527:0]     out_data;
    logic [36:0]      out_addr;
    logic [9:0]       out_src;

    int compared   = 0;
    int mismatched = 0;

    logic [584:0] pk [8];
    logic [584:0] pa, pb, p0, p1;
    logic [527:0] d1;

    tilexy_resp_link #(.TILE_X(2), .TILE_Y(0), .DIM(0), .DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_addr        (in_addr),
        .in_dst_x       (in_dst_x),
        .in_dst_y       (in_dst_y),
        .lane_in        (lane_in),
        .lane_in_vld    (lane_in_vld),
        .lane_stall_out (lane_stall_out),
        .lane_out       (lane_out),
        .lane_out_vld   (lane_out_vld),
        .lane_stall_in  (lane_stall_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_addr       (out_addr),
        .out_src        (out_src)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [584:0] mk_pkt(input logic [4:0] sy, input logic [4:0] sx,
                                            input logic [4:0] dy, input logic [4:0] dx,
                                            input logic [36:0] addr, input logic [527:0] data);
        return {sy, sx, dy, dx, addr, data};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [639:0] observed, input logic [639:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] lvld, input logic [584:0] lp0, input logic [584:0] lp1,
                                 input logic ivld, input logic [4:0] dx,
                                 input logic [36:0] addr, input logic [527:0] data);
        lane_in_vld = lvld;
        lane_in[0]  = lp0;
        lane_in[1]  = lp1;
        in_valid    = ivld;
        in_dst_x    = dx;
        in_dst_y    = 5'd0;
        in_addr     = addr;
        in_data     = data;
    endtask

    initial begin
        rst           = 1'b1;
        lane_stall_in = 2'b00;
        out_ready     = 1'b0;
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, '0, '0);
        tick;
        tick;
        rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_lane_out_vld", lane_out_vld, 2'b00);
        checkOutput("reset_lane_out", lane_out, '0);
        checkOutput("reset_stall_out", lane_stall_out, 2'b00);

        // forward inject
        d1 = {16{33'h1_2345_6789}};
        applyStimulus(2'b00, '0, '0, 1'b1, 5'd3, 37'h1000, d1);
        #1;
        checkOutput("inject_fwd_ready", in_ready, 1'b1);
        tick;
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, '0, '0);
        checkOutput("inject_fwd_vld", lane_out_vld, 2'b10);
        checkOutput("inject_fwd_pkt", lane_out[1], mk_pkt(5'd0, 5'd2, 5'd0, 5'd3, 37'h1000, d1));
        tick;
        checkOutput("inject_fwd_idle", lane_out_vld, 2'b00);

        // lane 0 eject and pop
        pa = mk_pkt(5'd0, 5'd1, 5'd0, 5'd2, 37'h0ABC, {66{8'hA5}});
        applyStimulus(2'b01, pa, '0, 1'b0, 5'd0, '0, '0);
        tick;
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, '0, '0);
        checkOutput("eject_valid", out_valid, 1'b1);
        checkOutput("eject_data", out_data, {66{8'hA5}});
        checkOutput("eject_addr", out_addr, 37'h0ABC);
        checkOutput("eject_src", out_src, 10'h001);
        checkOutput("eject_no_lane_out", lane_out_vld, 2'b00);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checkOutput("eject_popped", out_valid, 1'b0);

        // lane 1 transit under downstream stall
        lane_stall_in = 2'b10;
        for (int k = 0; k < 8; k++) pk[k] = mk_pkt(5'd0, 5'd1, 5'd0, 5'd5, 37'(k + 16), 528'(k * 7 + 3));
        for (int k = 0; k < 7; k++) begin
            applyStimulus(2'b10, '0, pk[k], 1'b0, 5'd0, '0, '0);
            tick;
            if (k == 5) checkOutput("transit_six_no_stall", lane_stall_out, 2'b00);
        end
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, '0, '0);
        checkOutput("transit_seven_stall", lane_stall_out, 2'b10);
        checkOutput("transit_held", lane_out_vld, 2'b00);
        // release stall with a simultaneous push at DEPTH-1
        lane_stall_in = 2'b00;
        applyStimulus(2'b10, '0, pk[7], 1'b0, 5'd0, '0, '0);
        tick;
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, '0, '0);
        checkOutput("transit_pushpop_stall", lane_stall_out, 2'b10);
        checkOutput("transit_out_vld_0", lane_out_vld, 2'b10);
        checkOutput("transit_out_pkt_0", lane_out[1], pk[0]);
        for (int k = 1; k < 8; k++) begin
            tick;
            checkOutput("transit_out_vld", lane_out_vld, 2'b10);
            checkOutput("transit_out_pkt", lane_out[1], pk[k]);
        end
        tick;
        checkOutput("transit_drained_vld", lane_out_vld, 2'b00);
        checkOutput("transit_drained_stall", lane_stall_out, 2'b00);

        // three eject writes in one cycle
        pa = mk_pkt(5'd0, 5'd1, 5'd0, 5'd2, 37'h11, 528'h111);
        pb = mk_pkt(5'd0, 5'd3, 5'd0, 5'd2, 37'h22, 528'h222);
        applyStimulus(2'b11, pa, pb, 1'b1, 5'd2, 37'h33, 528'h333);
        #1;
        checkOutput("loop_ready", in_ready, 1'b1);
        tick;
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, '0, '0);
        checkOutput("multi_no_lane_out", lane_out_vld, 2'b00);
        checkOutput("multi_head0_data", out_data, 528'h111);
        checkOutput("multi_head0_src", out_src, 10'h001);
        out_ready = 1'b1;
        tick;
        checkOutput("multi_head1_data", out_data, 528'h222);
        checkOutput("multi_head1_src", out_src, 10'h003);
        tick;
        checkOutput("multi_head2_data", out_data, 528'h333);
        checkOutput("multi_head2_addr", out_addr, 37'h33);
        checkOutput("multi_head2_src", out_src, 10'h002);
        tick;
        out_ready = 1'b0;
        checkOutput("multi_empty", out_valid, 1'b0);

        // inject to lane 0 waits for transit FIFO 0 to drain
        p0 = mk_pkt(5'd0, 5'd4, 5'd0, 5'd0, 37'h40, 528'h4040);
        p1 = mk_pkt(5'd0, 5'd4, 5'd0, 5'd1, 37'h41, 528'h4141);
        lane_stall_in = 2'b01;
        applyStimulus(2'b01, p0, '0, 1'b0, 5'd0, '0, '0);
        tick;
        applyStimulus(2'b01, p1, '0, 1'b0, 5'd0, '0, '0);
        tick;
        applyStimulus(2'b00, '0, '0, 1'b1, 5'd1, 37'h55, 528'h5555);
        #1;
        checkOutput("back_ready_stalled", in_ready, 1'b0);
        lane_stall_in = 2'b00;
        #1;
        checkOutput("back_ready_fifo_busy", in_ready, 1'b0);
        tick;
        checkOutput("back_out_vld_p0", lane_out_vld, 2'b01);
        checkOutput("back_out_p0", lane_out[0], p0);
        checkOutput("back_ready_one_left", in_ready, 1'b0);
        tick;
        checkOutput("back_out_p1", lane_out[0], p1);
        checkOutput("back_ready_drained", in_ready, 1'b1);
        tick;
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, '0, '0);
        checkOutput("back_inject_vld", lane_out_vld, 2'b01);
        checkOutput("back_inject_pkt", lane_out[0], mk_pkt(5'd0, 5'd2, 5'd0, 5'd1, 37'h55, 528'h5555));
        tick;
        checkOutput("back_idle", lane_out_vld, 2'b00);

        // fill the eject queue to the stall margin, then reset
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, mk_pkt(5'd1, 5'(k), 5'd0, 5'd2, 37'(k), 528'(k)),
                          mk_pkt(5'd1, 5'(k + 8), 5'd0, 5'd2, 37'(k + 8), 528'(k + 8)),
                          1'b0, 5'd0, '0, '0);
            tick;
            if (k == 1) checkOutput("fill_four_no_stall", lane_stall_out, 2'b00);
        end
        applyStimulus(2'b00, '0, '0, 1'b1, 5'd2, 37'h66, 528'h66);
        #1;
        checkOutput("fill_six_stall", lane_stall_out, 2'b11);
        checkOutput("fill_six_loop_ready", in_ready, 1'b0);
        checkOutput("fill_six_valid", out_valid, 1'b1);
        in_dst_x = 5'd3;
        #1;
        checkOutput("fill_fwd_ready", in_ready, 1'b1);
        tick;
        applyStimulus(2'b00, '0, '0, 1'b0, 5'd0, '0, '0);
        checkOutput("fill_fwd_vld", lane_out_vld, 2'b10);
        rst = 1'b1;
        tick;
        checkOutput("midreset_out_valid", out_valid, 1'b0);
        checkOutput("midreset_stall_out", lane_stall_out, 2'b00);
        checkOutput("midreset_lane_vld", lane_out_vld, 2'b00);
        checkOutput("midreset_lane_out", lane_out, '0);
        rst = 1'b0;
        tick;
        checkOutput("postreset_out_valid", out_valid, 1'b0);
        checkOutput("postreset_lane_vld", lane_out_vld, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
